// File: rtl/if_fetch_buf_pkg.sv
// Shared fetch-path constants and types for the instruction-fetch buffer.
package if_fetch_buf_pkg;

  localparam int unsigned INSTADDRBUS = 32;
  localparam int unsigned INSTBUS     = 32;
  localparam logic [INSTADDRBUS-1:0] ZEROWORD = 32'h0000_0000;
  localparam logic [INSTBUS-1:0]     NOPINST  = 32'h0000_0000;
  localparam logic RSTENABLE = 1'b1;

  typedef struct packed {
    logic [INSTADDRBUS-1:0] pc;
    logic [INSTBUS-1:0]     inst;
  } fetch_pair_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry {pc, inst, filled} ring: allocate at grant, fill oldest unfilled, pop head.
module if_fetch_fifo
  import if_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [INSTADDRBUS-1:0]   alloc_pc_i,
  input  logic                     fill_i,
  input  logic [INSTBUS-1:0]       fill_inst_i,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output logic [INSTADDRBUS-1:0]   head_pc_o,
  output logic [INSTBUS-1:0]       head_inst_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   unfilled_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [INSTADDRBUS-1:0] pc_q   [DEPTH];
  logic [INSTADDRBUS-1:0] pc_d   [DEPTH];
  logic [INSTBUS-1:0]     inst_q [DEPTH];
  logic [INSTBUS-1:0]     inst_d [DEPTH];
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          unfilled_q, unfilled_d;

  // Next-state: flush empties everything; otherwise alloc/fill/pop act independently.
  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    filled_d   = filled_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    if (flush_i) begin
      filled_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      unfilled_d = '0;
    end else begin
      if (alloc_i) begin
        pc_d[wr_ptr_q]     = alloc_pc_i;
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      // A fill popped in the same cycle (bypass) leaves without being marked filled.
      if (fill_i) begin
        inst_d[fill_ptr_q] = fill_inst_i;
        if (!(pop_i && (rd_ptr_q == fill_ptr_q))) begin
          filled_d[fill_ptr_q] = 1'b1;
        end
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (pop_i) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PW'(1);
      end
      count_d    = count_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_d = unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      pc_q       <= '{default: '0};
      inst_q     <= '{default: '0};
      filled_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      filled_q   <= filled_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign head_valid_o = filled_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign head_inst_o  = inst_q[rd_ptr_q];
  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch buffer: credit-gated imem requests, in-order response matching, flush discard.
// Optional same-cycle response-to-ID bypass when IF_FETCH_BUF_BYPASS_EN is defined.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTADDRBUS-1:0] pc_i,
  input  logic                   pc_ce_i,
  output logic                   pc_ready_o,
  output logic                   imem_req_o,
  output logic [INSTADDRBUS-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTBUS-1:0]     imem_rdata_i,
  output logic                   id_valid_o,
  output logic [INSTADDRBUS-1:0] id_pc_o,
  output logic [INSTBUS-1:0]     id_inst_o,
  input  logic                   id_ready_i,
  input  logic                   flush_i
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] unfilled;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] pend;
  logic [CW:0]   occ;
  logic          credit;
  logic          discarding;
  logic          fill;
  logic          pop;
  logic          bypass;
  logic          head_valid;
  logic [INSTADDRBUS-1:0] head_pc;
  logic [INSTBUS-1:0]     head_inst;
  fetch_pair_t   id_pair;

  if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .alloc_i      (pc_ready_o),
    .alloc_pc_i   (pc_i),
    .fill_i       (fill),
    .fill_inst_i  (imem_rdata_i),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_inst_o  (head_inst),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  // Request credit and handshakes.
  always_comb begin
    occ        = {1'b0, count} + {1'b0, discard_q};
    credit     = occ < (CW+1)'(DEPTH);
    imem_req_o = pc_ce_i && credit && !flush_i && (rst != RSTENABLE);
    imem_addr_o = pc_i;
    pc_ready_o = imem_req_o && imem_gnt_i;
    discarding = discard_q != '0;
    // Responses with nothing outstanding are dropped silently.
    fill       = imem_rvalid_i && !discarding && (unfilled != '0) && !flush_i;
`ifdef IF_FETCH_BUF_BYPASS_EN
    bypass     = fill && !head_valid;
`else
    bypass     = 1'b0;
`endif
    id_valid_o = head_valid || bypass;
    pop        = id_valid_o && id_ready_i && !flush_i;
  end

  // With no filled entry the oldest unfilled entry is the head, so head_pc pairs with the bypassed word.
  always_comb begin
    id_pair = '{pc: ZEROWORD, inst: NOPINST};
    if (head_valid) begin
      id_pair = '{pc: head_pc, inst: head_inst};
    end else if (bypass) begin
      id_pair = '{pc: head_pc, inst: imem_rdata_i};
    end
    id_pc_o   = id_pair.pc;
    id_inst_o = id_pair.inst;
  end

  // Discard counter: flush converts unfilled entries into responses to drop.
  always_comb begin
    pend      = discard_q + unfilled;
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = (imem_rvalid_i && (pend != '0)) ? pend - CW'(1) : pend;
    end else if (discarding && imem_rvalid_i) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Scoreboard bench for if_fetch_buf: PC-stage and latency-1 memory models, pop monitor, directed tests.
module tb_if_fetch_buf;

  localparam int unsigned DEPTH = 2;
`ifdef IF_FETCH_BUF_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_ce_i = 1'b0;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i = 1'b0;
  logic        flush_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int out_cnt = 0;
  int g0;
  logic        pc_adv = 1'b0;
  logic        mem_hold = 1'b0;
  logic [31:0] rsp_addr;
  logic [31:0] mem_q [$];
  logic [31:0] pc_q [$];
  exp_t        exp_q [$];
  int          pop_cyc [$];
  int          rsp_cyc [$];

  if_fetch_buf #(.DEPTH(DEPTH)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_ce_i       (pc_ce_i),
    .pc_ready_o    (pc_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_ready_i    (id_ready_i),
    .flush_i       (flush_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back('{pc: pc, inst: inst});
  endtask

  task automatic wait_grants(input int target, input int budget);
    for (int i = 0; i < budget && grant_cnt < target; i++) step();
    check("grant_wait", 32'(grant_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && pc_q.size() == 0 && mem_q.size() == 0 &&
          !imem_rvalid_i && !id_valid_o) break;
      step();
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) step();
  endtask

  // PC stage and memory drivers: act just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_q.delete();
      pc_q.delete();
      pc_adv = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i = '0;
    end else begin
      if (pc_adv) begin
        void'(pc_q.pop_front());
        pc_adv = 1'b0;
      end
      if (!mem_hold && mem_q.size() > 0) begin
        rsp_addr = mem_q.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i = inst_of(rsp_addr);
      end else begin
        imem_rvalid_i = 1'b0;
      end
    end
    pc_ce_i = pc_q.size() > 0;
    pc_i = (pc_q.size() > 0) ? pc_q[0] : 32'h0;
  end

  // Monitor: records grants/responses and scores every ID pop.
  always @(negedge clk) begin
    if (rst) begin
      out_cnt = 0;
    end else begin
      if (imem_rvalid_i) begin
        assert (out_cnt > 0) else $error("imem response with no outstanding request");
        if (out_cnt > 0) out_cnt--;
        rsp_cyc.push_back(cyc);
      end
      if (imem_req_o && imem_gnt_i) begin
        mem_q.push_back(imem_addr_o);
        out_cnt++;
        grant_cnt++;
        pc_adv = 1'b1;
      end
      if (id_valid_o && id_ready_i && !flush_i) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {31'h0, id_valid_o}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pop_pc", id_pc_o, e.pc);
          check("pop_inst", id_inst_o, e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) step();
    check("rst_req", {31'h0, imem_req_o}, 32'd0);
    check("rst_pc_ready", {31'h0, pc_ready_o}, 32'd0);
    check("rst_id_valid", {31'h0, id_valid_o}, 32'd0);
    check("rst_id_pc", id_pc_o, 32'h0);
    check("rst_id_inst", id_inst_o, 32'h0);
    rst = 1'b0;
    step();

    // Streaming
    imem_gnt_i = 1'b1;
    id_ready_i = 1'b1;
    pop_cyc.delete();
    rsp_cyc.delete();
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    push_exp(32'h8, 32'hC0DE_0008);
    pc_q.push_back(32'h0);
    pc_q.push_back(32'h4);
    pc_q.push_back(32'h8);
    wait_idle("stream_drain", 40);
    check("stream_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() >= 2 && rsp_cyc.size() >= 1) begin
      check("stream_back2back", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("stream_latency", 32'(pop_cyc[0] - rsp_cyc[0]), 32'(LAT));
    end

    // Backpressure
    id_ready_i = 1'b0;
    g0 = grant_cnt;
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    push_exp(32'h8, 32'hC0DE_0008);
    pc_q.push_back(32'h0);
    pc_q.push_back(32'h4);
    pc_q.push_back(32'h8);
    repeat (5) step();
    check("bp_grants", 32'(grant_cnt - g0), 32'd2);
    check("bp_req", {31'h0, imem_req_o}, 32'd0);
    check("bp_pc_ready", {31'h0, pc_ready_o}, 32'd0);
    check("bp_head_pc", id_pc_o, 32'h0);
    id_ready_i = 1'b1;
    wait_idle("bp_drain", 40);

    // In-flight flush: two outstanding responses dropped
    mem_hold = 1'b1;
    g0 = grant_cnt;
    pc_q.push_back(32'h10);
    pc_q.push_back(32'h14);
    wait_grants(g0 + 2, 20);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    check("flush_discard_cnt", 32'(u_dut.discard_q), 32'd2);
    check("flush_id_valid", {31'h0, id_valid_o}, 32'd0);
    push_exp(32'h40, 32'hC0DE_0040);
    pc_q.push_back(32'h40);
    mem_hold = 1'b0;
    wait_idle("flush_drain", 40);

    // Flush coinciding with the only outstanding response
    mem_hold = 1'b1;
    g0 = grant_cnt;
    pc_q.push_back(32'h20);
    wait_grants(g0 + 1, 20);
    mem_hold = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    check("flush_rsp_discard_cnt", 32'(u_dut.discard_q), 32'd0);
    check("flush_rsp_id_valid", {31'h0, id_valid_o}, 32'd0);
    repeat (3) step();
    check("flush_rsp_quiet", {31'h0, id_valid_o}, 32'd0);

    // Grant gaps: PC held while grant is low
    imem_gnt_i = 1'b0;
    push_exp(32'h80, 32'hC0DE_0080);
    push_exp(32'h84, 32'hC0DE_0084);
    pc_q.push_back(32'h80);
    pc_q.push_back(32'h84);
    step();
    imem_gnt_i = 1'b1;
    #1;
    check("gap0_pc_ready", {31'h0, pc_ready_o}, 32'd1);
    check("gap0_pc", pc_i, 32'h80);
    step();
    imem_gnt_i = 1'b0;
    #1;
    check("gap1_pc_ready", {31'h0, pc_ready_o}, 32'd0);
    check("gap1_req", {31'h0, imem_req_o}, 32'd1);
    check("gap1_pc", pc_i, 32'h84);
    step();
    imem_gnt_i = 1'b1;
    #1;
    check("gap2_pc_ready", {31'h0, pc_ready_o}, 32'd1);
    check("gap2_pc", pc_i, 32'h84);
    wait_idle("gap_drain", 40);

    // Reset with two entries buffered
    id_ready_i = 1'b0;
    pc_q.push_back(32'hA0);
    pc_q.push_back(32'hA4);
    repeat (6) step();
    check("prerst_valid", {31'h0, id_valid_o}, 32'd1);
    check("prerst_pc", id_pc_o, 32'hA0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("postrst_valid", {31'h0, id_valid_o}, 32'd0);
    check("postrst_pc", id_pc_o, 32'h0);
    check("postrst_inst", id_inst_o, 32'h0);
    check("postrst_pc_ready", {31'h0, pc_ready_o}, 32'd0);
    check("postrst_req", {31'h0, imem_req_o}, 32'd0);
    id_ready_i = 1'b1;
    repeat (4) step();
    check("postrst_quiet", {31'h0, id_valid_o}, 32'd0);

    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
